// File: rtl/alu_seq.sv
// Handshaked XM23 ALU: single-cycle ops plus iterative BCD DADD, registered result and {V,N,Z,C} flags.
// Optional macro ALU_SHIFT_EN adds SRA (op 12) and RRC (op 13).
module alu_seq #(
  parameter int WIDTH    = 16,
  parameter int DADD_DPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int DIG_BITS = 4 * DADD_DPC;
  localparam int N_STEPS  = WIDTH / DIG_BITS;
  localparam int CNT_W    = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_SUB = 4'd2, OP_SUBC = 4'd3;
  localparam logic [3:0] OP_DADD = 4'd4,  OP_CMP  = 4'd5,  OP_XOR = 4'd6, OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8,  OP_BIT  = 4'd9,  OP_BIC = 4'd10, OP_BIS = 4'd11;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SRA  = 4'd12, OP_RRC  = 4'd13;
`endif

  typedef enum logic {S_IDLE, S_DADD_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_flags;
  logic [WIDTH-1:0]     r_a, r_b, r_acc;
  logic                 r_dc;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_accept, w_is_dadd, w_last;
  logic [WIDTH-1:0]     w_bop, w_res;
  logic                 w_cin, w_vf, w_cf, w_nz_en;
  logic [WIDTH:0]       w_sum;
  logic [3:0]           w_flg;
  logic [4:0]           w_s;
  logic                 w_c;
  logic [DIG_BITS-1:0]  w_digits;
  logic [WIDTH-1:0]     w_acc_nxt;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_is_dadd = (op == OP_DADD);
  assign w_last    = (r_cnt == CNT_W'(N_STEPS - 1));

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // Shared adder: subtraction is a + ~b + cin, so V/C fall out of one carry chain.
  always_comb begin
    w_bop = b;
    w_cin = 1'b0;
    case (op)
      OP_ADDC:        w_cin = carry_in;
      OP_SUB, OP_CMP: begin w_bop = ~b; w_cin = 1'b1; end
      OP_SUBC:        begin w_bop = ~b; w_cin = carry_in; end
      default:        ;
    endcase
  end

  assign w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_res   = '0;
    w_vf    = 1'b0;
    w_cf    = 1'b0;
    w_nz_en = 1'b1;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        w_res = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = (a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:         w_res = a ^ b;
      OP_AND, OP_BIT: w_res = a & b;
      OP_OR,  OP_BIS: w_res = a | b;
      OP_BIC:         w_res = a & ~b;
`ifdef ALU_SHIFT_EN
      OP_SRA: begin w_res = {a[WIDTH-1], a[WIDTH-1:1]}; w_cf = a[0]; end
      OP_RRC: begin w_res = {carry_in,   a[WIDTH-1:1]}; w_cf = a[0]; end
`endif
      default:        w_nz_en = 1'b0;
    endcase
    w_flg = {w_vf, w_nz_en & w_res[WIDTH-1], w_nz_en & (w_res == '0), w_cf};
  end

  // BCD digits for this step, least significant first, rippling the decimal carry.
  always_comb begin
    w_c      = r_dc;
    w_s      = '0;
    w_digits = '0;
    for (int k = 0; k < DADD_DPC; k++) begin
      w_s = {1'b0, r_a[4*k +: 4]} + {1'b0, r_b[4*k +: 4]} + {4'b0, w_c};
      if (w_s > 5'd9) begin
        w_digits[4*k +: 4] = w_s[3:0] + 4'd6;
        w_c                = 1'b1;
      end else begin
        w_digits[4*k +: 4] = w_s[3:0];
        w_c                = 1'b0;
      end
    end
  end

  // Partial result fills from the top so it is aligned after the final step.
  assign w_acc_nxt = (r_acc >> DIG_BITS) | (WIDTH'(w_digits) << (WIDTH - DIG_BITS));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept && w_is_dadd) w_state_nxt = S_DADD_RUN;
      S_DADD_RUN: if (w_last)                w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_dc        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept && !w_is_dadd) begin
        r_result    <= w_res;
        r_flags     <= w_flg;
        r_out_valid <= 1'b1;
      end
      if (w_accept && w_is_dadd) begin
        r_a   <= a;
        r_b   <= b;
        r_dc  <= carry_in;
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_DADD_RUN) begin
        r_a   <= r_a >> DIG_BITS;
        r_b   <= r_b >> DIG_BITS;
        r_acc <= w_acc_nxt;
        r_dc  <= w_c;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_result    <= w_acc_nxt;
          r_flags     <= {1'b0, w_acc_nxt[WIDTH-1], w_acc_nxt == '0, w_c};
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq; a second instance with DADD_DPC=2 checks the shorter DADD latency.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, carry_in;
  logic        out_ready2 = 1'b1;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [15:0] result, result2;
  logic [3:0]  flags, flags2;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat1, lat2, rdy_low;
  logic [15:0] res1, res2;
  logic [3:0]  flg1, flg2;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .DADD_DPC(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags));

  alu_seq #(.WIDTH(16), .DADD_DPC(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op), .a(a), .b(b),
    .carry_in(carry_in), .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .flags(flags2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after accept, then record latency/result of both instances.
  task automatic run(input logic [3:0] t_op, input logic [15:0] t_a, input logic [15:0] t_b, input logic t_c);
    int g;
    g = 0;
    #1;
    while (!in_ready && g < 20) begin step(); g++; end
    check("accept_ready", in_ready, 1);
    op = t_op; a = t_a; b = t_b; carry_in = t_c; in_valid = 1'b1;
    step();
    in_valid = 1'b0; op = 4'hF; a = 16'hDEAD; b = 16'hBEEF; carry_in = ~t_c;
    #1;
    lat1 = -1; lat2 = -1; rdy_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (lat1 < 0 && out_valid)  begin lat1 = i; res1 = result;  flg1 = flags;  end
      if (lat2 < 0 && out_valid2) begin lat2 = i; res2 = result2; flg2 = flags2; end
      if (lat1 < 0 && !in_ready) rdy_low++;
      if (lat1 >= 0 && lat2 >= 0) break;
      step();
    end
  endtask

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0; carry_in = 1'b0;
    step(); step();
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result",    result,    0);
    check("rst_flags",     flags,     0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    run(4'd0, 16'h7FFF, 16'h0001, 1'b0);          // ADD overflow
    check("add_lat",    lat1, 0);
    check("add_result", res1, 16'h8000);
    check("add_flags",  flg1, 4'b1100);

    run(4'd2, 16'h0005, 16'h0005, 1'b0);          // SUB equal
    check("sub_result", res1, 16'h0000);
    check("sub_flags",  flg1, 4'b0011);

    run(4'd3, 16'h0000, 16'h0001, 1'b1);          // SUBC with borrow
    check("subc_result", res1, 16'hFFFF);
    check("subc_flags",  flg1, 4'b0100);

    run(4'd1, 16'hFFFF, 16'h0000, 1'b1);          // ADDC wraps to zero
    check("addc_result", res1, 16'h0000);
    check("addc_flags",  flg1, 4'b0011);

    run(4'd4, 16'h0999, 16'h0001, 1'b0);          // DADD ripple
    check("dadd1_lat",      lat1,    4);
    check("dadd1_rdy_low",  rdy_low, 4);
    check("dadd1_result",   res1,    16'h1000);
    check("dadd1_flags",    flg1,    4'b0000);
    check("dadd1_dpc2_res", res2,    16'h1000);

    run(4'd4, 16'h9999, 16'h0000, 1'b1);          // DADD full carry-out
    check("dadd2_result",   res1, 16'h0000);
    check("dadd2_flags",    flg1, 4'b0011);
    check("dadd2_dpc2_lat", lat2, 2);
    check("dadd2_dpc2_res", res2, 16'h0000);
    check("dadd2_dpc2_flg", flg2, 4'b0011);

    run(4'd14, 16'hFFFF, 16'hFFFF, 1'b1);         // undefined opcode
    check("undef_result", res1, 16'h0000);
    check("undef_flags",  flg1, 4'b0000);

`ifdef ALU_SHIFT_EN
    run(4'd13, 16'h0001, 16'h0000, 1'b1);         // RRC
    check("rrc_result", res1, 16'h8000);
    check("rrc_flags",  flg1, 4'b0101);
    run(4'd12, 16'h8003, 16'h0000, 1'b0);         // SRA
    check("sra_result", res1, 16'hC001);
    check("sra_flags",  flg1, 4'b0101);
`else
    run(4'd13, 16'h0001, 16'h0000, 1'b1);         // RRC absent: undefined
    check("op13_result", res1, 16'h0000);
    check("op13_flags",  flg1, 4'b0000);
`endif

    // Back-pressure: AND held while out_ready low, then XOR transfers on the same edge as the drain.
    step();
    out_ready = 1'b0;
    op = 4'd7; a = 16'hF0F0; b = 16'h0FF0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check("bp_out_valid", out_valid, 1);
    check("bp_result",    result,    16'h00F0);
    check("bp_in_ready",  in_ready,  0);
    step(); step();
    check("bp_hold_result", result,    16'h00F0);
    check("bp_hold_valid",  out_valid, 1);
    op = 4'd6; a = 16'hF0F0; b = 16'h0FF0; in_valid = 1'b1;
    #1;
    check("bp_blocked", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_released", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    check("xor_valid",  out_valid, 1);
    check("xor_result", result,    16'hFF00);
    check("xor_flags",  flags,     4'b0100);
    step();
    check("xor_drained", out_valid, 0);

    run(4'd10, 16'hFFFF, 16'h00FF, 1'b0);         // BIC leaves a nonzero result for the abort test
    check("bic_result", res1, 16'hFF00);
    check("bic_flags",  flg1, 4'b0100);

    // Reset in the second cycle of DADD_RUN.
    op = 4'd4; a = 16'h0999; b = 16'h0001; carry_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst", in_ready, 0);
    step();
    check("abort_out_valid", out_valid, 0);
    check("abort_result",    result,    16'h0000);
    check("abort_flags",     flags,     4'b0000);
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    run(4'd0, 16'h0001, 16'h0001, 1'b0);
    check("after_abort_lat",    lat1, 0);
    check("after_abort_result", res1, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
